pv_loader: RTL

PV_LOADER -- requirements
Module: pv_loader

---
 rtl/pv_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pv_loader.sv
// -----------------------------------------------------------------------------
// pv_loader
//   Loads one principal-variation line into a downstream PV table. Moves are
//   accepted one per cycle and turned into registered table-write words on
//   pv_ctrl_out. When the optional tail-clear feature is compiled in, the plies
//   past the end of the line are written back as invalid.
//
// Configuration macro:
//   PV_LOADER_TAIL_CLEAR_EN  - when defined, adds the TAIL state that invalidates
//                              plies pv_len..D-1 after a short line.
//
// Ports:
//   clk          in   clock, everything on the rising edge
//   reset        in   asynchronous active-low reset
//   load_start   in   one-cycle pulse, starts a new line (honoured in IDLE only)
//   mv_valid     in   a move is offered on mv_uci
//   mv_uci       in   [UCI_WIDTH]  move for the next ply
//   mv_last      in   offered move is the final move of the line
//   mv_ready     out  loader accepts the offered move (high in LOAD)
//   pv_ctrl_out  out  [32] table-write word:
//                       [31] strobe, [UCI_WIDTH-1:0] move,
//                       [UCI_WIDTH +: MAX_DEPTH_LOG2] ply,
//                       [UCI_WIDTH+MAX_DEPTH_LOG2] entry-valid
//   busy         out  loader is not idle
//   done         out  one-cycle pulse when a load completes
//   pv_len       out  [MAX_DEPTH_LOG2+1] moves stored by the last load
//   overflow     out  sticky: the last load offered more than D moves
// -----------------------------------------------------------------------------
module pv_loader #(
  parameter int UCI_WIDTH      = 0,
  parameter int MAX_DEPTH_LOG2 = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic                      mv_valid,
  input  logic [UCI_WIDTH-1:0]      mv_uci,
  input  logic                      mv_last,
  output logic                      mv_ready,
  output logic [31:0]               pv_ctrl_out,
  output logic                      busy,
  output logic                      done,
  output logic [MAX_DEPTH_LOG2:0]   pv_len,
  output logic                      overflow
);

  // Ply counter is one bit wider than the ply field so it can hold D itself.
  localparam int              PW        = MAX_DEPTH_LOG2 + 1;
  localparam logic [PW-1:0]   DEPTH     = PW'(1) << MAX_DEPTH_LOG2;
  localparam logic [PW-1:0]   LAST_PLY  = DEPTH - PW'(1);
  localparam int              VALID_BIT = UCI_WIDTH + MAX_DEPTH_LOG2;

  if (UCI_WIDTH + MAX_DEPTH_LOG2 + 1 > 31) begin : g_bad_params
    $error("pv_loader: UCI_WIDTH + MAX_DEPTH_LOG2 + 1 must not exceed 31");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
`ifdef PV_LOADER_TAIL_CLEAR_EN
    ST_TAIL,
`endif
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ply_q, ply_d;
  logic [PW-1:0]   len_q, len_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     ctrl_q, ctrl_d;
  logic            done_q;
  logic            armed_q;

  // Build one table-write word. The ply is always < D when a write is issued,
  // so the counter's extra top bit is zero and never leaks into the valid bit.
  function automatic logic [31:0] pack_write(input logic          valid,
                                             input logic [PW-1:0] ply,
                                             input logic [31:0]   mv);
    logic [31:0] w;
    w = 32'h8000_0000;
    w = w | mv;
    w = w | (32'(ply) << UCI_WIDTH);
    w = w | (32'(valid) << VALID_BIT);
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    ply_d   = ply_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    ctrl_d  = '0;
    case (state_q)
      ST_IDLE: begin
        // armed_q holds off load_start until the second edge after reset.
        if (load_start && armed_q) begin
          state_d = ST_LOAD;
          ply_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (mv_valid) begin
          if (ply_q < DEPTH) begin
            ctrl_d = pack_write(1'b1, ply_q, 32'(mv_uci));
            ply_d  = ply_q + PW'(1);
            len_d  = len_q + PW'(1);
          end else begin
            // Table full: consume the move silently and flag it.
            ovf_d = 1'b1;
          end
          if (mv_last) begin
`ifdef PV_LOADER_TAIL_CLEAR_EN
            state_d = (ply_d < DEPTH) ? ST_TAIL : ST_DONE;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef PV_LOADER_TAIL_CLEAR_EN
      ST_TAIL: begin
        ctrl_d = pack_write(1'b0, ply_q, 32'd0);
        ply_d  = ply_q + PW'(1);
        if (ply_q == LAST_PLY) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ply_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      ctrl_q  <= '0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ply_q   <= ply_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      ctrl_q  <= ctrl_d;
      // done follows the DONE state by one edge so it lands one cycle after
      // the final strobe of the line.
      done_q  <= (state_q == ST_DONE);
      armed_q <= 1'b1;
    end
  end

  assign mv_ready    = (state_q == ST_LOAD);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign pv_ctrl_out = ctrl_q;
  assign pv_len      = len_q;
  assign overflow    = ovf_q;

endmodule
